// File: rtl/subst_layer_seq.sv
// subst_layer_seq: time-multiplexed ASCON p_S layer, NB_SBOX columns per cycle.
// Build option SUBST_ABORT_EN adds an abort_i input that cancels a run.
module subst_sbox (
    input  logic [4:0] x,
    output logic [4:0] y
);
    logic a0, a1, a2, a3, a4;
    logic t0, t1, t2, t3, t4;
    logic b0, b1, b2, b3, b4;

    // Bitsliced ASCON sbox; bit 4 is lane x0, bit 0 is lane x4.
    assign a0 = x[4] ^ x[0];
    assign a1 = x[3];
    assign a2 = x[2] ^ x[3];
    assign a3 = x[1];
    assign a4 = x[0] ^ x[1];

    assign t0 = ~a0 & a1;
    assign t1 = ~a1 & a2;
    assign t2 = ~a2 & a3;
    assign t3 = ~a3 & a4;
    assign t4 = ~a4 & a0;

    assign b0 = a0 ^ t1;
    assign b1 = a1 ^ t2;
    assign b2 = a2 ^ t3;
    assign b3 = a3 ^ t4;
    assign b4 = a4 ^ t0;

    assign y = {b0 ^ b4, b1 ^ b0, ~b2, b3 ^ b2, b4};
endmodule

module subst_layer_seq #(
    parameter int NB_SBOX = 8
) (
    input  logic         clock_i,
    input  logic         resetb_i,
    input  logic         start_i,
`ifdef SUBST_ABORT_EN
    input  logic         abort_i,
`endif
    input  logic [319:0] state_i,
    output logic [319:0] state_o,
    output logic         busy_o,
    output logic         done_o
);
    localparam int NB_GROUPS = 64 / NB_SBOX;
    localparam int CW = (NB_GROUPS > 1) ? $clog2(NB_GROUPS) : 1;
    localparam int LOG_NB = $clog2(NB_SBOX);
    localparam logic [CW-1:0] LAST = CW'(NB_GROUPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t             fsm;
    logic [CW-1:0]    col_cnt;
    logic [5:0]       base;
    logic [4:0][63:0] lane;
    logic [4:0][63:0] nxt;
    logic [4:0]       sin  [NB_SBOX];
    logic [4:0]       sout [NB_SBOX];
    logic             abort;

    assign lane   = state_o;
    assign base   = 6'(col_cnt) << LOG_NB;
    assign busy_o = (fsm != IDLE);

`ifdef SUBST_ABORT_EN
    assign abort = abort_i && (fsm != IDLE);
`else
    assign abort = 1'b0;
`endif

    for (genvar g = 0; g < NB_SBOX; g++) begin : g_sb
        logic [5:0] c;
        assign c = base + 6'(g);
        assign sin[g] = {lane[4][c], lane[3][c], lane[2][c],
                         lane[1][c], lane[0][c]};
        subst_sbox u_sbox (
            .x (sin[g]),
            .y (sout[g])
        );
    end

    // Column j belongs to group j/NB_SBOX and is served by sbox j%NB_SBOX.
    for (genvar j = 0; j < 64; j++) begin : g_col
        localparam int S = j % NB_SBOX;
        localparam int G = j / NB_SBOX;
        logic hit;
        assign hit = (col_cnt == CW'(G));
        assign {nxt[4][j], nxt[3][j], nxt[2][j], nxt[1][j], nxt[0][j]} =
            hit ? sout[S]
                : {lane[4][j], lane[3][j], lane[2][j], lane[1][j], lane[0][j]};
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            fsm     <= IDLE;
            col_cnt <= '0;
            state_o <= '0;
            done_o  <= 1'b0;
        end else if (abort) begin
            fsm     <= IDLE;
            col_cnt <= '0;
            done_o  <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (start_i) begin
                        state_o <= state_i;
                        col_cnt <= '0;
                        fsm     <= RUN;
                    end
                end
                RUN: begin
                    state_o <= nxt;
                    if (col_cnt == LAST) begin
                        fsm     <= DONE;
                        done_o  <= 1'b1;
                        col_cnt <= '0;
                    end else begin
                        col_cnt <= col_cnt + CW'(1);
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    fsm    <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_subst_layer_seq.sv
// tb_subst_layer_seq: checks subst_layer_seq at NB_SBOX = 8, 1 and 64
// against a table-lookup model of the ASCON substitution layer.
module tb_subst_layer_seq;
    localparam logic [4:0] SB [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam logic [63:0] Z = 64'h0;
    localparam logic [63:0] F = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        string       nm;
        logic [319:0] s;
        logic [319:0] e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rstb = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [319:0] sin = '0;
    logic [319:0] so8, so1, so64;
    logic         busy8, busy1, busy64;
    logic         done8, done1, done64;

    int n_cmp = 0;
    int n_bad = 0;

    logic [319:0] res8, res8b, res1, res64;
    int lat8, lat1, lat64, nd8, nd1, nd64, nbusy8;
    logic b9, b10;

    always #5 clk = ~clk;

    subst_layer_seq #(.NB_SBOX(8)) u8 (
        .clock_i (clk), .resetb_i (rstb), .start_i (start),
`ifdef SUBST_ABORT_EN
        .abort_i (abort),
`endif
        .state_i (sin), .state_o (so8), .busy_o (busy8), .done_o (done8)
    );
    subst_layer_seq #(.NB_SBOX(1)) u1 (
        .clock_i (clk), .resetb_i (rstb), .start_i (start),
`ifdef SUBST_ABORT_EN
        .abort_i (abort),
`endif
        .state_i (sin), .state_o (so1), .busy_o (busy1), .done_o (done1)
    );
    subst_layer_seq #(.NB_SBOX(64)) u64 (
        .clock_i (clk), .resetb_i (rstb), .start_i (start),
`ifdef SUBST_ABORT_EN
        .abort_i (abort),
`endif
        .state_i (sin), .state_o (so64), .busy_o (busy64), .done_o (done64)
    );

    function automatic logic [319:0] ref_ps(input logic [319:0] s);
        logic [4:0][63:0] x;
        logic [4:0][63:0] y;
        logic [4:0] v;
        x = s;
        y = x;
        for (int j = 0; j < 64; j++) begin
            v = {x[4][j], x[3][j], x[2][j], x[1][j], x[0][j]};
            {y[4][j], y[3][j], y[2][j], y[1][j], y[0][j]} = SB[v];
        end
        return y;
    endfunction

    function automatic logic [319:0] rnd_state();
        logic [319:0] s;
        for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [319:0] act,
                       input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstb = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
    endtask

    // One start pulse (or start held high with state_i switched to s2),
    // then 70 edges of observation; c counts edges after the capture edge.
    task automatic run(input logic [319:0] s, input bit hold,
                       input logic [319:0] s2);
        @(negedge clk);
        sin = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (hold) sin = s2;
        else start = 1'b0;
        lat8 = 0; lat1 = 0; lat64 = 0;
        nd8 = 0; nd1 = 0; nd64 = 0;
        nbusy8 = 0;
        b9 = 1'bx; b10 = 1'bx;
        res8 = 'x; res8b = 'x; res1 = 'x; res64 = 'x;
        @(negedge clk);
        if (busy8) nbusy8++;
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy8 && c <= 9) nbusy8++;
            if (c == 9) b9 = busy8;
            if (c == 10) b10 = busy8;
            if (done8) begin
                nd8++;
                if (nd8 == 1) begin lat8 = c; res8 = so8; end
                else if (nd8 == 2) res8b = so8;
            end
            if (done1) begin
                nd1++;
                if (nd1 == 1) begin lat1 = c; res1 = so1; end
            end
            if (done64) begin
                nd64++;
                if (nd64 == 1) begin lat64 = c; res64 = so64; end
            end
        end
        start = 1'b0;
    endtask

    task automatic run_check(input string nm, input logic [319:0] s,
                             input logic [319:0] e);
        run(s, 1'b0, '0);
        chk({nm, " res8"}, res8, e);
        chk({nm, " res1"}, res1, e);
        chk({nm, " res64"}, res64, e);
        chki({nm, " lat8"}, lat8, 8);
        chki({nm, " lat1"}, lat1, 64);
        chki({nm, " lat64"}, lat64, 1);
        chki({nm, " ndone8"}, nd8, 1);
        chki({nm, " ndone1"}, nd1, 1);
        chki({nm, " busy8 cycles"}, nbusy8, 9);
        chk({nm, " hold8"}, so8, e);
    endtask

    vec_t vt[3];
    logic [319:0] a, b, r;
    int ndone;

    initial begin
        vt[0] = '{"zero", '0, {Z, Z, F, Z, Z}};
        vt[1] = '{"ones", {F, F, F, F, F}, {F, Z, F, F, F}};
        vt[2] = '{"col0", {Z, Z, Z, Z, 64'h1},
                  {Z, 64'h1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 64'h1}};

        #12;
        chk("reset so8", so8, '0);
        chki("reset busy8", int'(busy8), 0);
        chki("reset done8", int'(done8), 0);
        chk("reset so64", so64, '0);
        @(negedge clk);
        rstb = 1'b1;

        for (int i = 0; i < 3; i++) run_check(vt[i].nm, vt[i].s, vt[i].e);

        for (int i = 0; i < 6; i++) begin
            r = rnd_state();
            run_check($sformatf("rnd%0d", i), r, ref_ps(r));
        end

        a = rnd_state();
        b = rnd_state();
        run(a, 1'b1, b);
        chk("held start first", res8, ref_ps(a));
        chk("held start second", res8b, ref_ps(b));
        chki("held busy8 cycles", nbusy8, 9);
        chki("held busy after done", int'(b9), 0);
        chki("held restart busy", int'(b10), 1);
        apply_reset();

        r = rnd_state();
        @(negedge clk);
        sin = r;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstb = 1'b0;
        #1;
        chk("midreset so8", so8, '0);
        chki("midreset busy8", int'(busy8), 0);
        chki("midreset done8", int'(done8), 0);
        chk("midreset so1", so1, '0);
        @(negedge clk);
        rstb = 1'b1;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || done1 || done64) ndone++;
        end
        chki("midreset no done", ndone, 0);
        r = rnd_state();
        run_check("after reset", r, ref_ps(r));

`ifdef SUBST_ABORT_EN
        r = rnd_state();
        @(negedge clk);
        sin = r;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chki("abort busy8", int'(busy8), 0);
        chki("abort busy1", int'(busy1), 0);
        ndone = 0;
        repeat (70) begin
            @(negedge clk);
            if (done8 || done1) ndone++;
        end
        chki("abort no done", ndone, 0);
        r = rnd_state();
        run_check("after abort", r, ref_ps(r));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/subst_layer_seq.md
Name: subst_layer_seq

Overview:
Time-multiplexed ASCON substitution layer (p_S) controller. Applies the 5-bit sbox to all 64 columns of the 320-bit state, NB_SBOX columns per cycle, using NB_SBOX instances of the existing sbox module. Sits between the permutation round controller (start/done handshake) and the state register datapath. It trades area for latency against a fully parallel 64-sbox layer.

Parameters:
NB_SBOX, 8, sbox instances / columns processed per cycle; legal values 1,2,4,8,16,32,64 (must divide 64).
NB_GROUPS, 64/NB_SBOX, derived localparam; number of RUN cycles.

Ports:
clock_i  in  1  system clock, rising edge.
resetb_i  in  1  asynchronous, active-low reset.
start_i  in  1  start request; sampled only in IDLE.
state_i  in  320  input state {x0,x1,x2,x3,x4}; x0 = [319:256], x4 = [63:0].
state_o  out  320  working/result state register, same packing.
busy_o  out  1  high while FSM is not IDLE.
done_o  out  1  one-cycle completion pulse, registered.

Behaviour:
- Reset (async, resetb_i=0): FSM=IDLE, col_cnt=0, state_o=0, done_o=0, busy_o=0. Reset mid-operation aborts immediately; no done_o.
- Column j (0..63) sbox input = {x0[j],x1[j],x2[j],x3[j],x4[j]}, with x0 as MSB (bit 4). Output bit 4 is written back to x0[j], down to bit 0 to x4[j].
- FSM states: IDLE, RUN, DONE.
- IDLE: on an edge with start_i=1, load state_o <= state_i, col_cnt <= 0, go to RUN. start_i=0 keeps state_o unchanged.
- RUN: each edge substitutes columns col_cnt*NB_SBOX .. col_cnt*NB_SBOX+NB_SBOX-1 in state_o (ascending from column 0). All other columns hold. col_cnt increments.
- RUN exit: on the edge that processes group NB_GROUPS-1, go to DONE, set done_o <= 1, and wrap col_cnt to 0.
- DONE: the next edge clears done_o and returns to IDLE.
- Result validity: state_o holds the final result from the done_o cycle until the next accepted start_i.
- Latency: done_o is high in the cycle after the NB_GROUPS-th edge following start capture. The NB_SBOX=8 default gives 8 edges, plus 1 DONE cycle before a new start is accepted.
- busy_o: combinational decode of FSM != IDLE. It is high during RUN and DONE.
- start_i while busy_o=1 is ignored and not queued. Callers must wait for busy_o=0.
- During RUN, state_o shows a partially substituted state and is not to be consumed.
- state_i is sampled only on the start edge; later changes have no effect.
- col_cnt width is clog2(NB_GROUPS), minimum 1 bit. For NB_SBOX=64 the block makes a single RUN cycle.

Optional Feature:
Macro SUBST_ABORT_EN.
- Defined: adds port abort_i (in, 1). abort_i=1 on any edge in RUN or DONE forces IDLE, col_cnt=0, done_o=0. state_o keeps its partial contents. abort_i has priority over start_i and over the RUN-to-DONE transition. abort_i in IDLE has no effect.
- Undefined: no abort_i port; RUN always runs to completion, barring reset.

Test Plan:
- Zero state: state_i=0, start pulse -> done_o one cycle after 8 RUN edges (NB_SBOX=8); state_o x2=0xFFFF_FFFF_FFFF_FFFF, x0=x1=x3=x4=0 (S(0x00)=0x04).
- All-ones state: state_i all 1s -> x1=0, and x0, x2, x3, x4 each =0xFFFF_FFFF_FFFF_FFFF (S(0x1F)=0x17).
- Single column: x4=0x1, others 0 -> x0=0, x1=0x1, x2=0xFFFF_FFFF_FFFF_FFFE, x3=0x1, x4=0x1 (S(0x01)=0x0B on col 0, 0x04 elsewhere).
- start_i held high through RUN with a different state_i -> result matches the first captured state; next run starts only after DONE→IDLE; busy_o high for exactly 9 cycles per run.
- resetb_i asserted after 3 RUN edges -> outputs 0 immediately, no done_o. A fresh start then gives the correct result.
- Parameter sweep NB_SBOX=1, 8, 64 with random states versus a reference model -> identical state_o; done_o latency 64/8/1 edges. With SUBST_ABORT_EN, abort at RUN edge 2 -> IDLE, no done_o.
